uart_tx_param: RTL and testbench

Parametrised UART transmitter that serialises one word per valid/ready handshake onto a single line: start bit, data LSB-first, optional parity, then 1 or 2 stop bits. It is the configurable successor to the fixed 8N1 transmitter. It sits between a byte/word source (FIFO or register interface) and the TX pad, in the tx_clk domain. Unlike the previous generation, it latches data only on an explicit handshake and reports completion.

---
 rtl/uart_tx_param.sv | 136 +++++++++++++
 tb/tb_uart_tx_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART serialiser, start + DATA_BITS LSB-first + optional parity (UART_TX_PARITY_EN) + 1/2 stop bits.
// Latency: start bit on the line the cycle after the accepting edge; frame = (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready only in IDLE; a held tx_valid waits out the frame plus one idle cycle.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 521,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 tx_clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_tx_param: illegal parameter set");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par_bit;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   stop_cnt;
    logic                   tc;
    logic                   last_stop;

    assign tc        = (cnt == CNT_LAST);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
    assign tx_ready  = (state == IDLE);
    assign tx_busy   = (state != IDLE);

    // tx_out is loaded with the level of the bit being entered, so the line tracks state with no extra delay.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            stop_cnt <= 1'b0;
            tx_out   <= 1'b1;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                cnt <= tc ? '0 : cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shift   <= tx_data;
`ifdef UART_TX_PARITY_EN
                        par_bit <= (^tx_data) ^ PARITY_ODD[0];
`endif
                        cnt     <= '0;
                        tx_out  <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (tc) begin
                        bit_idx <= '0;
                        tx_out  <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tc) begin
                        shift <= shift >> 1;
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx_out   <= par_bit;
                            state    <= PARITY;
`else
                            tx_out   <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_out  <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tc) begin
                        tx_out   <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Registered one cycle early so the pulse lands on the final stop cycle.
                    if (last_stop && cnt == CNT_PRE) begin
                        tx_done <= 1'b1;
                    end
                    if (tc) begin
                        if (last_stop) begin
                            state <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_out <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: two instances (8-bit/1 stop/even, 7-bit/2 stop/odd) at 4 clocks per bit.
module tb_uart_tx_param;
    localparam int CPB = 4;

    logic tx_clk;
    logic rst_n;
    logic [7:0] a_data;
    logic a_valid, a_ready, a_out, a_busy, a_done;
    logic [6:0] b_data;
    logic b_valid, b_ready, b_out, b_busy, b_done;

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .tx_clk(tx_clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx_out(a_out), .tx_busy(a_busy), .tx_done(a_done));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .tx_clk(tx_clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx_out(b_out), .tx_busy(b_busy), .tx_done(b_done));

    // line[i] is the i-th bit period on the wire (start bit first)
    typedef struct {
        logic [11:0] line;
        int          nbits;
        logic        par;
    } frame_t;

    frame_t q_a[$];
    frame_t q_b[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic frame_t mk_a(input logic [7:0] d, input logic par);
        frame_t f;
        f.par = par;
`ifdef UART_TX_PARITY_EN
        f.line  = {1'b0, 1'b1, par, d, 1'b0};
        f.nbits = 11;
`else
        f.line  = {2'b00, 1'b1, d, 1'b0};
        f.nbits = 10;
`endif
        return f;
    endfunction

    function automatic frame_t mk_b(input logic [6:0] d, input logic par);
        frame_t f;
        f.par = par;
`ifdef UART_TX_PARITY_EN
        f.line  = {1'b0, 2'b11, par, d, 1'b0};
        f.nbits = 11;
`else
        f.line  = {2'b00, 2'b11, d, 1'b0};
        f.nbits = 10;
`endif
        return f;
    endfunction

    function automatic logic [63:0] expand(input frame_t f);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < f.nbits; i++)
            for (int j = 0; j < CPB; j++)
                v[i*CPB + j] = f.line[i];
        return v;
    endfunction

    // Monitors: record the line every busy cycle, compare on tx_done.
    logic [63:0] rec_a = '0;
    logic [63:0] rec_b = '0;
    int n_a = 0;
    int n_b = 0;
    frame_t fa, fb;

    always @(negedge tx_clk) begin
        if (!rst_n) begin
            n_a = 0;
            rec_a = '0;
        end else begin
            if (a_busy && n_a < 64) begin
                rec_a[n_a] = a_out;
                n_a++;
            end
            if (a_done) begin
                chk("a_done_ready_excl", {63'd0, a_ready}, 64'd0);
                chk("a_done_expected", {63'd0, q_a.size() > 0}, 64'd1);
                if (q_a.size() > 0) begin
                    fa = q_a.pop_front();
                    chk("a_frame_len", 64'(n_a), 64'(fa.nbits * CPB));
                    chk("a_frame_bits", rec_a, expand(fa));
                end
                n_a = 0;
                rec_a = '0;
            end
        end
    end

    always @(negedge tx_clk) begin
        if (!rst_n) begin
            n_b = 0;
            rec_b = '0;
        end else begin
            if (b_busy && n_b < 64) begin
                rec_b[n_b] = b_out;
                n_b++;
            end
            if (b_done) begin
                chk("b_done_ready_excl", {63'd0, b_ready}, 64'd0);
                chk("b_done_expected", {63'd0, q_b.size() > 0}, 64'd1);
                if (q_b.size() > 0) begin
                    fb = q_b.pop_front();
                    chk("b_frame_len", 64'(n_b), 64'(fb.nbits * CPB));
                    chk("b_frame_bits", rec_b, expand(fb));
                end
                n_b = 0;
                rec_b = '0;
            end
        end
    end

    task automatic wait_accept_a;
        int k = 0;
        while (!a_busy && k < 100) begin
            @(negedge tx_clk);
            k++;
        end
        chk("a_accept", {63'd0, a_busy}, 64'd1);
    endtask

    task automatic wait_accept_b;
        int k = 0;
        while (!b_busy && k < 100) begin
            @(negedge tx_clk);
            k++;
        end
        chk("b_accept", {63'd0, b_busy}, 64'd1);
    endtask

    task automatic wait_done_a;
        int k = 0;
        while (!a_done && k < 200) begin
            @(negedge tx_clk);
            k++;
        end
        chk("a_done_seen", {63'd0, a_done}, 64'd1);
    endtask

    task automatic wait_done_b;
        int k = 0;
        while (!b_done && k < 200) begin
            @(negedge tx_clk);
            k++;
        end
        chk("b_done_seen", {63'd0, b_done}, 64'd1);
    endtask

    task automatic send_a(input logic [7:0] d, input logic par, input bit expect_frame);
        @(negedge tx_clk);
        a_data  = d;
        a_valid = 1'b1;
        if (expect_frame) q_a.push_back(mk_a(d, par));
        wait_accept_a();
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [6:0] d, input logic par);
        @(negedge tx_clk);
        b_data  = d;
        b_valid = 1'b1;
        q_b.push_back(mk_b(d, par));
        wait_accept_b();
        b_valid = 1'b0;
    endtask

    initial begin
        int k;
        int seen;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
        repeat (3) @(negedge tx_clk);
        chk("rst_a_out_ready_busy_done", {60'd0, a_out, a_ready, a_busy, a_done}, 64'b1100);
        chk("rst_b_out_ready_busy_done", {60'd0, b_out, b_ready, b_busy, b_done}, 64'b1100);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge tx_clk);
            chk("idle_a", {61'd0, a_out, a_ready, a_busy}, 64'b110);
        end

        // even parity: A5 has four ones, 07 has three
        send_a(8'hA5, 1'b0, 1'b1);
        wait_done_a();
        send_a(8'h07, 1'b1, 1'b1);
        wait_done_a();

        // odd parity: 41 has two ones, 7F has seven
        send_b(7'h41, 1'b1);
        wait_done_b();
        send_b(7'h7F, 1'b0);
        wait_done_b();

        // back-to-back with tx_valid held and tx_data disturbed mid-frame
        @(negedge tx_clk);
        a_data  = 8'h55;
        a_valid = 1'b1;
        q_a.push_back(mk_a(8'h55, 1'b0));
        q_a.push_back(mk_a(8'hAA, 1'b0));
        wait_accept_a();
        a_data = 8'h3C;
        repeat (9) @(negedge tx_clk);
        a_data = 8'hF0;
        wait_done_a();
        a_data = 8'hAA;
        k = 0;
        do begin
            @(negedge tx_clk);
            k++;
        end while (!(a_busy && !a_out) && k < 10);
        chk("b2b_start_gap", 64'(k), 64'd2);
        a_valid = 1'b0;
        wait_done_a();

        // asynchronous reset during data bit 3 of 8'h00
        send_a(8'h00, 1'b0, 1'b0);
        repeat (17) @(negedge tx_clk);
        chk("abort_pre_line", {63'd0, a_out}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_ready_busy", {61'd0, a_out, a_ready, a_busy}, 64'b110);
        repeat (3) @(negedge tx_clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge tx_clk);
            if (a_done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        send_a(8'hFF, 1'b0, 1'b1);
        wait_done_a();

        repeat (5) @(negedge tx_clk);
        chk("a_queue_empty", 64'(q_a.size()), 64'd0);
        chk("b_queue_empty", 64'(q_b.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
